// File: rtl/seq_pkg.sv
// seq_pkg: shared sizes and index types for the pattern sequencer
package seq_pkg;
    localparam int NUM_TRACKS = 4;
    localparam int NUM_STEPS  = 8;
    typedef logic [2:0] step_t;
    typedef logic [1:0] track_t;
endpackage

// File: rtl/trig_pulse.sv
// trig_pulse: fixed-width trigger pulse, restarted by every start strobe
module trig_pulse #(
    parameter int TRIG_LEN = 50000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic start,
    output logic pulse
);
    localparam int W = $clog2(TRIG_LEN + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge CLOCK_50) begin
        if (reset)
            cnt <= '0;
        else if (start)
            cnt <= W'(TRIG_LEN);
        else if (cnt != '0)
            cnt <= cnt - W'(1);
    end
    assign pulse = cnt != '0;
endmodule

// File: rtl/pattern_sequencer.sv
// pattern_sequencer: 4x8 step drum pattern with cursor editing and per-track trigger pulses
module pattern_sequencer
    import seq_pkg::*;
#(
    parameter int TRIG_LEN = 50000
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic [31:0] beatNum,
    input  logic        beatClk,
    input  logic [1:0]  track_sel,
    input  logic        key_toggle,
    input  logic        key_next,
    input  logic        key_prev,
    input  logic        clear_all,
    output logic [3:0]  trig,
    output logic [7:0]  pattern_leds,
    output logic [2:0]  cursor,
    output logic [7:0]  playhead
);
    logic [NUM_TRACKS-1:0][NUM_STEPS-1:0] pattern;
    step_t  prev_step, adv_step;
    track_t sel;
    logic   adv, tog_q, next_q, prev_q;
    logic   tog_e, next_e, prev_e, step_change;
    assign sel         = track_sel;
    assign tog_e       = key_toggle & ~tog_q;
    assign next_e      = key_next & ~next_q;
    assign prev_e      = key_prev & ~prev_q;
    assign step_change = (beatNum <= 32'd7) && (beatNum[2:0] != prev_step);
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pattern   <= '0;
            cursor    <= '0;
            prev_step <= '0;
            adv_step  <= '0;
            adv       <= 1'b0;
            tog_q     <= 1'b0;
            next_q    <= 1'b0;
            prev_q    <= 1'b0;
        end else begin
            tog_q  <= key_toggle;
            next_q <= key_next;
            prev_q <= key_prev;
            adv    <= step_change;
            if (step_change) begin
                prev_step <= beatNum[2:0];
                adv_step  <= beatNum[2:0];
            end
            if (next_e && !prev_e)
                cursor <= cursor + 3'd1;
            else if (prev_e && !next_e)
                cursor <= cursor - 3'd1;
            // clear wins over a same-cycle toggle
            if (clear_all)
                pattern <= '0;
            else if (tog_e)
                pattern[sel][cursor] <= ~pattern[sel][cursor];
        end
    end
    // start samples the stored cell, so a same-edge toggle does not affect this trigger
    for (genvar t = 0; t < NUM_TRACKS; t++) begin : g_trk
        trig_pulse #(.TRIG_LEN(TRIG_LEN)) u_pulse (
            .CLOCK_50(CLOCK_50),
            .reset(reset),
            .start(adv && pattern[t][adv_step]),
            .pulse(trig[t])
        );
    end
    always_comb begin
        pattern_leds = pattern[sel];
        playhead     = beatClk ? (8'b1 << prev_step) : 8'b0;
    end
endmodule

// File: tb/tb_pattern_sequencer.sv
// tb_pattern_sequencer: directed self-checking bench with TRIG_LEN=4
module tb_pattern_sequencer;
    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic [31:0] beatNum;
    logic        beatClk;
    logic [1:0]  track_sel;
    logic        key_toggle, key_next, key_prev, clear_all;
    logic [3:0]  trig;
    logic [7:0]  pattern_leds, playhead;
    logic [2:0]  cursor;
    int errors = 0;
    int checks = 0;

    pattern_sequencer #(.TRIG_LEN(4)) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .beatNum(beatNum), .beatClk(beatClk),
        .track_sel(track_sel), .key_toggle(key_toggle), .key_next(key_next),
        .key_prev(key_prev), .clear_all(clear_all), .trig(trig),
        .pattern_leds(pattern_leds), .cursor(cursor), .playhead(playhead)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic tick;
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic press(input logic t, input logic n, input logic p);
        key_toggle = t; key_next = n; key_prev = p;
        tick();
        key_toggle = 0; key_next = 0; key_prev = 0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1; beatNum = 0; beatClk = 1; track_sel = 0;
        key_toggle = 0; key_next = 0; key_prev = 0; clear_all = 0;
        tick(); tick();
        reset = 0;
        tick();
        checks++; if (trig !== 4'b0) begin errors++; $display("FAIL reset_trig: got %b want 0000", trig); end
        checks++; if (cursor !== 3'd0) begin errors++; $display("FAIL reset_cursor: got %0d want 0", cursor); end
        checks++; if (pattern_leds !== 8'h00) begin errors++; $display("FAIL reset_leds: got %b want 00000000", pattern_leds); end
        checks++; if (playhead !== 8'h01) begin errors++; $display("FAIL reset_playhead: got %b want 00000001", playhead); end
        for (int i = 0; i < 5; i++) tick();
        checks++; if (trig !== 4'b0) begin errors++; $display("FAIL reset_no_step0_trig: got %b want 0000", trig); end
    endtask

    task automatic test_edit_trigger;
        logic [3:0] exp;
        track_sel = 2;
        for (int i = 0; i < 3; i++) press(0, 1, 0);
        checks++; if (cursor !== 3'd3) begin errors++; $display("FAIL edit_cursor: got %0d want 3", cursor); end
        press(1, 0, 0);
        checks++; if (pattern_leds !== 8'b0000_1000) begin errors++; $display("FAIL edit_leds: got %b want 00001000", pattern_leds); end
        track_sel = 0;
        #1;
        checks++; if (pattern_leds !== 8'h00) begin errors++; $display("FAIL edit_sel_comb: got %b want 00000000", pattern_leds); end
        track_sel = 2;
        beatNum = 2;
        for (int i = 0; i < 4; i++) tick();
        checks++; if (trig !== 4'b0) begin errors++; $display("FAIL edit_step2_quiet: got %b want 0000", trig); end
        beatNum = 3;
        for (int i = 1; i <= 8; i++) begin
            tick();
            exp = (i >= 2 && i <= 5) ? 4'b0100 : 4'b0000;
            checks++; if (trig !== exp) begin errors++; $display("FAIL edit_trig_c%0d: got %b want %b", i, trig, exp); end
        end
        checks++; if (playhead !== 8'b0000_1000) begin errors++; $display("FAIL edit_playhead: got %b want 00001000", playhead); end
        beatClk = 0;
        #1;
        checks++; if (playhead !== 8'h00) begin errors++; $display("FAIL edit_playhead_gated: got %b want 00000000", playhead); end
        beatClk = 1;
    endtask

    task automatic test_cursor_wrap;
        for (int i = 0; i < 3; i++) press(0, 0, 1);
        checks++; if (cursor !== 3'd0) begin errors++; $display("FAIL wrap_back_to0: got %0d want 0", cursor); end
        press(0, 0, 1);
        checks++; if (cursor !== 3'd7) begin errors++; $display("FAIL wrap_prev: got %0d want 7", cursor); end
        key_next = 1;
        for (int i = 0; i < 10; i++) tick();
        key_next = 0;
        tick();
        checks++; if (cursor !== 3'd0) begin errors++; $display("FAIL wrap_next_held: got %0d want 0", cursor); end
        press(0, 1, 1);
        checks++; if (cursor !== 3'd0) begin errors++; $display("FAIL wrap_both: got %0d want 0", cursor); end
    endtask

    task automatic test_retrigger;
        int highs, rises;
        logic last;
        beatNum = 0;
        for (int i = 0; i < 8; i++) tick();
        track_sel = 0;
        for (int i = 0; i < 8; i++) begin
            press(1, 0, 0);
            press(0, 1, 0);
        end
        checks++; if (pattern_leds !== 8'hFF) begin errors++; $display("FAIL retrig_fill: got %b want 11111111", pattern_leds); end
        highs = 0; rises = 0; last = 0;
        beatNum = 1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (i == 2) beatNum = 2;
            if (trig[0]) highs++;
            if (trig[0] && !last) rises++;
            last = trig[0];
        end
        checks++; if (highs != 6) begin errors++; $display("FAIL retrig_len: got %0d want 6", highs); end
        checks++; if (rises != 1) begin errors++; $display("FAIL retrig_continuous: got %0d rises want 1", rises); end
        checks++; if (trig !== 4'b0) begin errors++; $display("FAIL retrig_end: got %b want 0000", trig); end
    endtask

    task automatic test_clear_priority;
        clear_all = 1; key_toggle = 1;
        tick();
        clear_all = 0; key_toggle = 0;
        tick();
        for (int t = 0; t < 4; t++) begin
            track_sel = 2'(t);
            #1;
            checks++; if (pattern_leds !== 8'h00) begin errors++; $display("FAIL clear_track%0d: got %b want 00000000", t, pattern_leds); end
        end
        beatNum = 9;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (trig !== 4'b0) begin errors++; $display("FAIL clear_beat9_trig: got %b want 0000", trig); end
        end
        checks++;
        checks++; if (playhead !== 8'b0000_0100) begin errors++; $display("FAIL clear_beat9_step: got %b want 00000100", playhead); end
    endtask

    task automatic test_reset_mid_pulse;
        track_sel = 1;
        press(1, 0, 0);
        checks++; if (pattern_leds !== 8'h01) begin errors++; $display("FAIL rmid_setup: got %b want 00000001", pattern_leds); end
        beatNum = 0;
        tick();
        tick();
        checks++; if (trig !== 4'b0010) begin errors++; $display("FAIL rmid_first: got %b want 0010", trig); end
        tick();
        checks++; if (trig !== 4'b0010) begin errors++; $display("FAIL rmid_second: got %b want 0010", trig); end
        reset = 1;
        tick();
        checks++; if (trig !== 4'b0) begin errors++; $display("FAIL rmid_trig: got %b want 0000", trig); end
        checks++; if (pattern_leds !== 8'h00) begin errors++; $display("FAIL rmid_pattern: got %b want 00000000", pattern_leds); end
        reset = 0;
        for (int i = 0; i < 3; i++) tick();
        checks++; if (trig !== 4'b0) begin errors++; $display("FAIL rmid_after: got %b want 0000", trig); end
    endtask

    initial begin
        test_reset();
        test_edit_trigger();
        test_cursor_wrap();
        test_retrigger();
        test_clear_priority();
        test_reset_mid_pulse();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 Parameter TRIG_LEN, default 50000; trigger pulse width in CLOCK_50 cycles (1 ms).
REQ-002 CLOCK_50  input  1  system clock, 50 MHz.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 beatNum  input  32  current step from the beat clock stage; valid range 0..7.
REQ-005 beatClk  input  1  beat clock, 50 % duty; used only for display gating.
REQ-006 track_sel  input  2  track being edited, 0..3.
REQ-007 key_toggle  input  1  level, active-high, pre-synchronised; flips the cell under the cursor.
REQ-008 key_next / key_prev  input  1 each  level, active-high, pre-synchronised; move the cursor.
REQ-009 clear_all  input  1  level, active-high; erases the whole pattern.
REQ-010 trig  output  4  per-track drum trigger pulses.
REQ-011 pattern_leds  output  8  the 8 step bits of the selected track.
REQ-012 cursor  output  3  edit cursor position.
REQ-013 playhead  output  8  one-hot current step, ANDed with beatClk.

Function
REQ-014 Pattern storage: 4 tracks x 8 steps of 1-bit registers.
REQ-015 Step advance: fires one cycle after beatNum[2:0] differs from the registered prev_step, provided beatNum <= 7.
REQ-016 On a step advance, prev_step takes the new value.
REQ-017 A beatNum value greater than 7 causes no advance and leaves prev_step unchanged.
REQ-018 On an advance to step s, every track t with pattern[t][s]=1 drives trig[t] high for exactly TRIG_LEN cycles, starting the cycle after detection.
REQ-019 An advance that hits a track whose pulse is still active restarts its count, giving TRIG_LEN cycles from the new start.
REQ-020 Edit-key edge detection: each of key_toggle, key_next and key_prev acts only on its 0->1 transition.
REQ-021 A held key produces one action only.
REQ-022 key_next: cursor+1, wrapping 7->0.
REQ-023 key_prev: cursor-1, wrapping 0->7.
REQ-024 Rising edges on key_next and key_prev in the same cycle: cursor unchanged.
REQ-025 key_toggle edge: pattern[track_sel][cursor] inverts on the following clock.
REQ-026 clear_all high: all 32 cells are 0 on the next clock.
REQ-027 clear_all has priority over a simultaneous toggle edge.
REQ-028 A toggle and a step advance on the same cell in the same cycle: the trigger uses the pre-toggle value.
REQ-029 pattern_leds: combinational view of pattern[track_sel].
REQ-030 track_sel changes take effect on pattern_leds in the same cycle.
REQ-031 playhead = (8'b1 << prev_step) when beatClk=1, else 0.
REQ-032 After reset, step 0 does not trigger until the sequence wraps 7->0.

Reset
REQ-033 Reset values: pattern all 0, cursor 0, prev_step 0, key edge registers 0, trig 0, all pulse counters 0.
REQ-034 Reset asserted mid-pulse forces trig to 0 on the next clock.
REQ-035 Reset asserted mid-edit discards any pending edge.

Structure
REQ-036 Shared package seq_pkg holds NUM_TRACKS=4, NUM_STEPS=8, step_t (3-bit) and track_t (2-bit).
REQ-037 Sub-module trig_pulse (start in, pulse out, TRIG_LEN parameter, own counter), instantiated once per track.
REQ-038 All state changes on posedge CLOCK_50; no other clocks; beatClk is never used as a clock.

Verification (bench uses TRIG_LEN=4)
REQ-039 Reset, then beatNum held 0 -> trig=0, cursor=0, pattern_leds=0.
REQ-040 Edit and trigger:
- Stimulus: track_sel=2, key_next pulsed 3 times, then key_toggle pulsed.
- Required: cursor=3, pattern_leds=8'b0000_1000.
- Then beatNum 2->3: trig=4'b0100 for exactly 4 cycles, starting 2 cycles after the beatNum change.
REQ-041 Cursor wrap:
- key_prev pulsed from cursor=0 -> cursor=7.
- key_next held high for 10 cycles -> cursor advances by 1 only.
REQ-042 Retrigger: pattern[0] all 1s; beatNum changes 0->1, then 1->2 two cycles later -> trig[0] high continuously, 6 cycles in total.
REQ-043 Clear priority:
- Stimulus: clear_all and a key_toggle edge in the same cycle.
- Required: all pattern bits 0, including the cell under the cursor.
- Then beatNum=9 -> no trig, prev_step unchanged.
REQ-044 Reset mid-pulse: reset asserted on the 2nd cycle of an active trig -> trig=0 on the next clock; pattern cleared.
